// File: rtl/hamming_decoder_7_4.sv
// Hamming(7,4) receive decoder: single-error correction through a two-stage
// enable-gated pipeline, plus a saturating count of corrected words.
module hamming_decoder_7_4 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [6:0]       code_in,
   input  logic             valid_in,
   input  logic             cnt_clr,
   output logic [3:0]       data_out,
   output logic             valid_out,
   output logic             err_corrected,
   output logic [2:0]       syndrome_out,
   output logic [CNT_W-1:0] err_count
);

   // Valid-only stream, no backpressure: a word is live when valid_in=1 at an
   // edge with ena=1; valid_out qualifies every other output.

   logic [6:0]       code1_q, code1_d;
   logic             valid1_q, valid1_d;
   logic [2:0]       syn1_q, syn1_d;
   logic [3:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [2:0]       syn_q, syn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       flip;
   logic [6:0]       fixed;

   always_comb begin
      code1_d  = code1_q;
      valid1_d = valid1_q;
      syn1_d   = syn1_q;
      if (ena) begin
         code1_d  = code_in;
         valid1_d = valid_in;
         syn1_d   = {code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6],
                     code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6],
                     code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6]};
      end
   end

   // Syndrome 0 shifts the one-hot into bit 0, which is discarded: no flip.
   always_comb begin
      flip  = 8'd1 << syn1_q;
      fixed = code1_q ^ flip[7:1];
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      syn_d   = syn_q;
      if (ena) begin
         data_d  = {fixed[6], fixed[5], fixed[4], fixed[2]};
         valid_d = valid1_q;
         err_d   = (syn1_q != 3'd0);
         syn_d   = syn1_q;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (ena && valid1_q && (syn1_q != 3'd0) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code1_q  <= '0;
         valid1_q <= 1'b0;
         syn1_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         syn_q    <= '0;
         cnt_q    <= '0;
      end else begin
         code1_q  <= code1_d;
         valid1_q <= valid1_d;
         syn1_q   <= syn1_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         syn_q    <= syn_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data_out      = data_q;
   assign valid_out     = valid_q;
   assign err_corrected = err_q;
   assign syndrome_out  = syn_q;
   assign err_count     = cnt_q;

endmodule

// File: tb/tb_hamming_decoder_7_4.sv
// Bench for hamming_decoder_7_4: directed table, exhaustive single-error sweep,
// stall/reset/saturation sequences and random traffic against a reference model.
module tb_hamming_decoder_7_4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [6:0] code_in = '0;
   logic       valid_in = 1'b0;
   logic       cnt_clr = 1'b0;

   logic [3:0] data_out, data_out_s;
   logic       valid_out, valid_out_s;
   logic       err_corrected, err_corrected_s;
   logic [2:0] syndrome_out, syndrome_out_s;
   logic [7:0] err_count;
   logic [1:0] err_count_s;

   int errors = 0;
   int checks = 0;

   hamming_decoder_7_4 #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .code_in(code_in), .valid_in(valid_in),
      .cnt_clr(cnt_clr), .data_out(data_out), .valid_out(valid_out),
      .err_corrected(err_corrected), .syndrome_out(syndrome_out), .err_count(err_count)
   );

   hamming_decoder_7_4 #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .ena(ena), .code_in(code_in), .valid_in(valid_in),
      .cnt_clr(cnt_clr), .data_out(data_out_s), .valid_out(valid_out_s),
      .err_corrected(err_corrected_s), .syndrome_out(syndrome_out_s), .err_count(err_count_s)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Syndrome is the XOR of the 1-based positions of all set bits.
   function automatic logic [7:0] ref_decode(input logic [6:0] c);
      int syn;
      logic [6:0] f;
      logic [2:0] s3;
      syn = 0;
      for (int p = 1; p <= 7; p++) if (c[p-1]) syn = syn ^ p;
      f = c;
      if (syn != 0) f[syn-1] = ~f[syn-1];
      s3 = syn[2:0];
      return {f[6], f[5], f[4], f[2], s3, (syn != 0)};
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p1, p2, p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   function automatic logic [6:0] pos_mask(input int pos);
      logic [7:0] m;
      m = 8'd1 << pos;
      return m[7:1];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Entry: {data[3:0], syndrome[2:0], err, tag[15:0]}; tag = enabled-edge count
   // at which the word must be showing on valid_out.
   logic [23:0] exp_q[$];
   logic [15:0] edge_cnt;
   logic        last_ena, last_clr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         last_ena <= 1'b0;
         last_clr <= 1'b0;
         exp_q.delete();
      end else begin
         last_ena <= ena;
         last_clr <= cnt_clr;
         if (ena) begin
            edge_cnt <= edge_cnt + 16'd1;
            if (valid_in) exp_q.push_back({ref_decode(code_in), edge_cnt + 16'd2});
         end
      end
   end

   int          cnt_m, cnt_s;
   logic [8:0]  prev_o;
   logic [23:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         cnt_m  = 0;
         cnt_s  = 0;
         prev_o = '0;
      end else begin
         if (last_ena) begin
            if (exp_q.size() > 0 && exp_q[0][15:0] == edge_cnt) begin
               e = exp_q.pop_front();
               chk("valid_out", valid_out, 1);
               chk("data_out", data_out, e[23:20]);
               chk("syndrome_out", syndrome_out, e[19:17]);
               chk("err_corrected", err_corrected, e[16]);
               chk("small_data_out", data_out_s, e[23:20]);
               if (!last_clr && e[16]) begin
                  if (cnt_m < 255) cnt_m++;
                  if (cnt_s < 3) cnt_s++;
               end
            end else begin
               chk("valid_out_idle", valid_out, 0);
            end
         end else begin
            chk("stall_hold", {data_out, valid_out, err_corrected, syndrome_out}, prev_o);
         end
         if (last_clr) begin
            cnt_m = 0;
            cnt_s = 0;
         end
         chk("err_count", err_count, cnt_m);
         chk("err_count_small", err_count_s, cnt_s);
         prev_o = {data_out, valid_out, err_corrected, syndrome_out};
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [6:0] c, input logic v, input logic en, input logic cl);
      @(negedge clk);
      #1;
      code_in  = c;
      valid_in = v;
      ena      = en;
      cnt_clr  = cl;
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) drive(7'h00, 1'b0, 1'b1, 1'b0);
   endtask

   typedef struct {
      logic [6:0] code;
      logic [3:0] data;
      logic [2:0] syn;
      logic       err;
   } vec_t;

   vec_t vecs[10];

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{7'h55, 4'hB, 3'd0, 1'b0};
      vecs[1] = '{7'h45, 4'hB, 3'd5, 1'b1};
      vecs[2] = '{7'h00, 4'h0, 3'd0, 1'b0};
      vecs[3] = '{7'h7F, 4'hF, 3'd0, 1'b0};
      vecs[4] = '{7'h54, 4'hB, 3'd1, 1'b1};
      vecs[5] = '{7'h51, 4'hB, 3'd3, 1'b1};
      vecs[6] = '{7'h15, 4'hB, 3'd7, 1'b1};
      vecs[7] = '{7'h5D, 4'hB, 3'd4, 1'b1};
      vecs[8] = '{7'h20, 4'h0, 3'd6, 1'b1};
      vecs[9] = '{7'h56, 4'hA, 3'd3, 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_data_out", data_out, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_err_count", err_count, 0);
      #1 rst_n = 1'b1;
      flush(2);

      // directed table, one word at a time
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].code, 1'b1, 1'b1, 1'b0);
         drive(7'h00, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), valid_out, 1);
         chk($sformatf("tbl%0d_data", i), data_out, vecs[i].data);
         chk($sformatf("tbl%0d_syn", i), syndrome_out, vecs[i].syn);
         chk($sformatf("tbl%0d_err", i), err_corrected, vecs[i].err);
      end

      // every data value with each error position (0 = clean), back to back
      for (int d = 0; d < 16; d++)
         for (int p = 0; p < 8; p++)
            drive(encode(4'(d)) ^ pos_mask(p), 1'b1, 1'b1, 1'b0);
      flush(3);

      // stream with a 3-cycle stall; stalled words are dropped
      for (int i = 0; i < 19; i++)
         drive(encode(4'(i)) ^ pos_mask(i % 8), 1'b1, !(i >= 6 && i <= 8), 1'b0);
      flush(3);

      // saturation and clear
      drive(7'h00, 1'b0, 1'b1, 1'b1);
      drive(7'h00, 1'b0, 1'b1, 1'b0);
      chk("clr_count", err_count, 0);
      for (int i = 0; i < 5; i++) drive(encode(4'(i + 3)) ^ pos_mask(i + 1), 1'b1, 1'b1, 1'b0);
      flush(3);
      chk("sat_small", err_count_s, 3);
      chk("count_five", err_count, 5);
      drive(7'h00, 1'b0, 1'b0, 1'b1);
      drive(7'h00, 1'b0, 1'b1, 1'b0);
      chk("clr_no_ena", err_count, 0);
      drive(encode(4'h9) ^ pos_mask(6), 1'b1, 1'b1, 1'b0);
      flush(3);
      chk("count_one", err_count, 1);
      drive(encode(4'h6) ^ pos_mask(2), 1'b1, 1'b1, 1'b0);
      drive(7'h00, 1'b0, 1'b1, 1'b1);
      drive(7'h00, 1'b0, 1'b1, 1'b0);
      chk("coinc_err_flag", err_corrected, 1);
      chk("coinc_clr", err_count, 0);
      chk("coinc_clr_small", err_count_s, 0);

      // random traffic
      for (int i = 0; i < 400; i++)
         drive(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
      flush(3);

      // mid-stream asynchronous reset
      for (int i = 0; i < 4; i++) drive(encode(4'(i)) ^ pos_mask(3), 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data_out", data_out, 0);
      chk("arst_valid_out", valid_out, 0);
      chk("arst_err_corrected", err_corrected, 0);
      chk("arst_syndrome_out", syndrome_out, 0);
      chk("arst_err_count", err_count, 0);
      chk("arst_err_count_small", err_count_s, 0);
      @(negedge clk);
      #1;
      rst_n    = 1'b1;
      valid_in = 1'b0;
      flush(4);
      chk("post_rst_valid", valid_out, 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
